// File: rtl/d_hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard.
package d_hazard_scoreboard_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // Forwarding select codes: 0 = register file, k = pipeline stage k
   localparam int unsigned FWD_SEL_GRF = 0;
   localparam int unsigned FWD_SEL_E   = 1;
   localparam int unsigned FWD_SEL_M   = 2;
   localparam int unsigned FWD_SEL_W   = 3;

   // Default multiply/divide unit busy latencies
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   // Width of a forwarding select able to name every tracked stage plus the GRF
   function automatic int unsigned fwd_width(input int unsigned stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/d_hazard_scoreboard_if.sv
// Decode-stage hazard interface: controller fields in, stall/forward selects out.
interface d_hazard_scoreboard_if
   import d_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned STAGES = 3,
   parameter int unsigned TNEW_W = 2
);

   localparam int unsigned FWD_W = fwd_width(STAGES);

   logic [REG_W-1:0]  d_rs;
   logic [REG_W-1:0]  d_rt;
   logic [TNEW_W-1:0] rs_Tuse;
   logic [TNEW_W-1:0] rt_Tuse;
   logic [REG_W-1:0]  d_WriteReg;
   logic [TNEW_W-1:0] d_Tnew;
   logic              d_isMDU_instr;
   logic              d_mdu_start;
   logic              d_mdu_div;
   logic              stall;
   logic [FWD_W-1:0]  Forward_rs_D;
   logic [FWD_W-1:0]  Forward_rt_D;
   logic              mdu_busy;

   modport master (
      output d_rs, d_rt, rs_Tuse, rt_Tuse, d_WriteReg, d_Tnew,
             d_isMDU_instr, d_mdu_start, d_mdu_div,
      input  stall, Forward_rs_D, Forward_rt_D, mdu_busy
   );

   modport slave (
      input  d_rs, d_rt, rs_Tuse, rt_Tuse, d_WriteReg, d_Tnew,
             d_isMDU_instr, d_mdu_start, d_mdu_div,
      output stall, Forward_rs_D, Forward_rt_D, mdu_busy
   );

endinterface

// File: rtl/d_hazard_scoreboard_mdu.sv
// Multiply/divide busy counter: loads the op latency on issue, then counts down.
module d_mdu_busy_counter
   import d_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic div,
   output logic busy
);

   localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load latency on issue, else decrement toward zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/d_hazard_scoreboard.sv
// Decode-stage hazard unit: pending-write scoreboard that shifts with the pipe,
// producing forwarding selects, the D-stage stall and the MDU interlock.
module d_hazard_scoreboard
   import d_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned STAGES      = 3,
   parameter int unsigned TNEW_W      = 2,
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   d_hazard_scoreboard_if.slave  bus
);

   localparam int unsigned FWD_W = fwd_width(STAGES);

   logic              valid_q [1:STAGES];
   logic              valid_d [1:STAGES];
   logic [REG_W-1:0]  dst_q   [1:STAGES];
   logic [REG_W-1:0]  dst_d   [1:STAGES];
   logic [TNEW_W-1:0] tnew_q  [1:STAGES];
   logic [TNEW_W-1:0] tnew_d  [1:STAGES];

   logic [STAGES:1]   hit_rs;
   logic [STAGES:1]   hit_rt;
   logic              haz_rs;
   logic              haz_rt;
   logic [FWD_W-1:0]  fwd_rs;
   logic [FWD_W-1:0]  fwd_rt;
   logic              mdu_busy;
   logic              mdu_stall;
   logic              stall;

   // Per-stage address match; $0 never matches
   for (genvar k = 1; k <= STAGES; k++) begin : g_match
      assign hit_rs[k] = valid_q[k] && (dst_q[k] == bus.d_rs) && (bus.d_rs != REG_ZERO);
      assign hit_rt[k] = valid_q[k] && (dst_q[k] == bus.d_rt) && (bus.d_rt != REG_ZERO);
   end

   // Nearest matching stage decides: ready -> forward, too late -> hazard
   always_comb begin
      logic found_rs;
      logic found_rt;
      fwd_rs   = FWD_W'(FWD_SEL_GRF);
      fwd_rt   = FWD_W'(FWD_SEL_GRF);
      haz_rs   = 1'b0;
      haz_rt   = 1'b0;
      found_rs = 1'b0;
      found_rt = 1'b0;
      for (int unsigned k = 1; k <= STAGES; k++) begin
         if (!found_rs && hit_rs[k]) begin
            found_rs = 1'b1;
            if (tnew_q[k] == '0) begin
               fwd_rs = FWD_W'(k);
            end else if (tnew_q[k] > bus.rs_Tuse) begin
               haz_rs = 1'b1;
            end
         end
         if (!found_rt && hit_rt[k]) begin
            found_rt = 1'b1;
            if (tnew_q[k] == '0) begin
               fwd_rt = FWD_W'(k);
            end else if (tnew_q[k] > bus.rt_Tuse) begin
               haz_rt = 1'b1;
            end
         end
      end
   end

   assign mdu_stall = bus.d_isMDU_instr & mdu_busy;
   assign stall     = haz_rs | haz_rt | mdu_stall;

   // Scoreboard shift: D enters stage 1 (bubble on stall), older entries age
   always_comb begin
      valid_d[1] = !stall && (bus.d_WriteReg != REG_ZERO);
      dst_d[1]   = stall ? REG_ZERO : bus.d_WriteReg;
      tnew_d[1]  = stall ? '0 : bus.d_Tnew;
      for (int unsigned k = 2; k <= STAGES; k++) begin
         valid_d[k] = valid_q[k-1];
         dst_d[k]   = dst_q[k-1];
         tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
      end
   end

   // Scoreboard registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 1; k <= STAGES; k++) begin
            valid_q[k] <= 1'b0;
            dst_q[k]   <= REG_ZERO;
            tnew_q[k]  <= '0;
         end
      end else begin
         for (int unsigned k = 1; k <= STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            dst_q[k]   <= dst_d[k];
            tnew_q[k]  <= tnew_d[k];
         end
      end
   end

   // An MDU op only starts when it actually leaves D
   d_mdu_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_mdu_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (bus.d_mdu_start & ~stall),
      .div   (bus.d_mdu_div),
      .busy  (mdu_busy)
   );

   assign bus.stall        = stall;
   assign bus.Forward_rs_D = fwd_rs;
   assign bus.Forward_rt_D = fwd_rt;
   assign bus.mdu_busy     = mdu_busy;

endmodule

// File: tb/tb_d_hazard_scoreboard.sv
// Directed bench for the decode-stage hazard scoreboard.
module tb_d_hazard_scoreboard;

   logic clk;
   logic reset;
   int   total;
   int   passed;

   d_hazard_scoreboard_if #(.STAGES(3), .TNEW_W(2)) bus ();

   d_hazard_scoreboard #(
      .STAGES(3), .TNEW_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic st, input logic [1:0] frs,
                             input logic [1:0] frt, input logic busy);
      chk({tag, ".stall"}, 8'(bus.stall), 8'(st));
      chk({tag, ".fwd_rs"}, 8'(bus.Forward_rs_D), 8'(frs));
      chk({tag, ".fwd_rt"}, 8'(bus.Forward_rt_D), 8'(frt));
      chk({tag, ".busy"}, 8'(bus.mdu_busy), 8'(busy));
   endtask

   task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rs_tu,
                      input logic [1:0] rt_tu, input logic [4:0] wr, input logic [1:0] tn,
                      input logic ismdu, input logic start, input logic dv);
      bus.d_rs          = rs;
      bus.d_rt          = rt;
      bus.rs_Tuse       = rs_tu;
      bus.rt_Tuse       = rt_tu;
      bus.d_WriteReg    = wr;
      bus.d_Tnew        = tn;
      bus.d_isMDU_instr = ismdu;
      bus.d_mdu_start   = start;
      bus.d_mdu_div     = dv;
      #1;
   endtask

   task automatic nop();
      drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b1;
      nop();
      tick();
      tick();
      expect_out("reset", 1'b0, 2'd0, 2'd0, 1'b0);
      reset = 1'b0;

      // lw $1 (Tnew=2) then addu $2,$1,$3 (rs Tuse=1): one-cycle stall
      drv(5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("lw_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
      drv(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
      expect_out("lw_use_stall", 1'b1, 2'd0, 2'd0, 1'b0);
      tick();
      expect_out("lw_use_go", 1'b0, 2'd0, 2'd0, 1'b0);
      flush();

      // addu $1 (Tnew=1) then beq $1,$1 (Tuse=0): stall, then forward from M
      drv(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
      tick();
      drv(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("beq_stall", 1'b1, 2'd0, 2'd0, 1'b0);
      tick();
      expect_out("beq_fwd_m", 1'b0, 2'd2, 2'd2, 1'b0);
      flush();

      // lui $4 (Tnew=0) then jr $4 at distance 1, 2, 3
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("jr_fwd_e", 1'b0, 2'd1, 2'd0, 1'b0);
      flush();
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      nop();
      tick();
      drv(5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("jr_fwd_m", 1'b0, 2'd2, 2'd0, 1'b0);
      flush();
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      nop();
      tick();
      tick();
      drv(5'd0, 5'd4, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("jr_fwd_w_rt", 1'b0, 2'd0, 2'd3, 1'b0);
      flush();

      // lw $4 then lui $4: the nearer (ready) lui wins, no stall
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("lui_after_lw", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
      drv(5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("nearest_wins", 1'b0, 2'd1, 2'd1, 1'b0);
      flush();

      // Write to $0 never creates a hazard or forward
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("reg_zero", 1'b0, 2'd0, 2'd0, 1'b0);
      flush();

      // mult then mflo: 5 busy/stall cycles
      drv(5'd6, 5'd7, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      expect_out("mult_issue", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         expect_out($sformatf("mflo_wait%0d", i), 1'b1, 2'd0, 2'd0, 1'b1);
         tick();
      end
      expect_out("mflo_go", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
      flush();

      // div, an unrelated ALU op (no stall), then mflo for the rest of 10 cycles
      drv(5'd6, 5'd7, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      tick();
      drv(5'd3, 5'd3, 2'd1, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
      expect_out("div_alu_free", 1'b0, 2'd0, 2'd0, 1'b1);
      tick();
      drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i <= 10; i++) begin
         chk($sformatf("div_wait%0d.stall", i), 8'(bus.stall), 8'd1);
         tick();
      end
      expect_out("div_go", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
      flush();

      // Reset during div busy with a pending lw $1
      drv(5'd6, 5'd7, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      tick();
      drv(5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      drv(5'd1, 5'd0, 2'd1, 2'd3, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0);
      expect_out("pre_reset", 1'b1, 2'd0, 2'd0, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_out("post_reset", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
      nop();
      expect_out("post_reset2", 1'b0, 2'd0, 2'd0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/d_hazard_scoreboard.md
Name: d_hazard_scoreboard

Overview:
- Parametrised decode-stage hazard unit. Replaces per-pair Tuse/Tnew comparison with a pending-write scoreboard that shifts in lock-step with the pipeline.
- Generates the decode-stage forwarding selects (Forward_rs_D / Forward_rt_D encoding), the D-stage stall, and an MDU busy interlock with configurable mult/div latency.
- Sits beside the decode stage. Consumes the decode controller's Tuse/Tnew/WriteReg/MDU outputs.

Parameters:
- STAGES, 3, number of tracked post-D stages (1=E, 2=M, 3=W).
- TNEW_W, 2, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, busy cycles after mult/multu issue.
- DIV_CYCLES, 10, busy cycles after div/divu issue.
- FWD_W, derived localparam = clog2(STAGES+1), forwarding select width (2 at default).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- d_rs  in  5  rs field of instruction in D
- d_rt  in  5  rt field of instruction in D
- rs_Tuse  in  TNEW_W  cycles until rs is needed, counted from D
- rt_Tuse  in  TNEW_W  cycles until rt is needed, counted from D
- d_WriteReg  in  5  destination register of instruction in D; 0 means no write
- d_Tnew  in  TNEW_W  cycles after entering E until the result is available
- d_isMDU_instr  in  1  D instruction uses the MDU (mult/div/mf/mt)
- d_mdu_start  in  1  D instruction starts an MDU operation
- d_mdu_div  in  1  qualifies d_mdu_start: 1 = div latency, 0 = mult latency
- stall  out  1  freeze PC/IFID and insert a bubble into IDEX
- Forward_rs_D  out  FWD_W  0 = GRF; k = value from stage k (1 IDEX, 2 EXMEM, 3 MEMWB)
- Forward_rt_D  out  FWD_W  same encoding as Forward_rs_D, for rt
- mdu_busy  out  1  MDU counter is non-zero

Behaviour:
- Clock and reset: single clk; reset is synchronous and active-high.
- Reset: every entry valid=0, dst=0, tnew=0; MDU counter=0; stall=0; Forward_*=0; mdu_busy=0.
- Scoreboard: array entry[1..STAGES], each holding {valid, dst[4:0], tnew}.
- Update, every posedge clk, unconditionally:
  - entry[k+1] <= entry[k], with tnew decremented and saturating at 0.
  - entry[1] <= stall ? bubble (valid=0) : {d_WriteReg!=0, d_WriteReg, d_Tnew}.
  - entry[STAGES] is discarded when it shifts out.
- Match per source src ∈ {rs, rt}:
  - Take the lowest k with entry[k].valid and entry[k].dst==src and src!=0. Nearer stages win.
  - No match -> Forward=0, no hazard.
  - Match with tnew==0 -> Forward=k, no hazard.
  - Match with tnew > Tuse_src -> hazard, Forward=0.
  - Match with 0 < tnew <= Tuse_src -> Forward=0, no hazard (a later stage forwards).
- Stall: stall = hazard_rs | hazard_rt | mdu_stall. All outputs are combinational from the registered state and current inputs; D-input-to-stall latency is 0 cycles.
- MDU counter:
  - Loads MULT_CYCLES or DIV_CYCLES on a clock edge where d_mdu_start=1 and stall=0.
  - Otherwise decrements when non-zero.
  - mdu_busy = (counter != 0).
  - mdu_stall = d_isMDU_instr & mdu_busy.
- Simultaneous events:
  - A stalled d_mdu_start does not load the counter.
  - A load while the counter is non-zero cannot occur, because the instruction would be stalled.
- $0 is never a hazard and never a forward source.
- Reset asserted mid-operation clears the scoreboard and counter on that edge. stall deasserts in the following cycle, unless the current D inputs themselves create a hazard.

Decomposition:
- Shared macros.v gets:
  - forward-select codes FWD_GRF=0, FWD_E=1, FWD_M=2, FWD_W=3;
  - default MULT/DIV latencies;
  - reg_zero, reused.
- Natural sub-module: d_mdu_busy_counter (load/decrement counter with mdu_busy output). Scoreboard and match logic stay in the top module via a generate loop.

Test Plan:
1. lw $1 (d_Tnew=2) followed by addu $2,$1,$3 (rs_Tuse=1) -> stall=1 for exactly 1 cycle; next cycle entry[2] tnew=1, stall=0, Forward_rs_D=0.
2. addu $1 (d_Tnew=1) followed by beq $1,$1 (Tuse=0) -> 1-cycle stall; next cycle Forward_rs_D=Forward_rt_D=2.
3. lui $4 (d_Tnew=0) followed by jr $4 -> no stall, Forward_rs_D=1. Same lui followed by a nop and then jr -> Forward=2. Two nops before jr -> Forward=3.
4. Instruction writes $0 with d_Tnew=2, then a $0 consumer with Tuse=0 -> stall=0, Forward=0.
5. mult (d_mdu_start=1, d_mdu_div=0) followed by mflo -> mdu_busy high 5 cycles, stall high 5 cycles, mflo issues on cycle 6. div variant -> 10 cycles. Non-MDU instructions during busy -> no stall.
6. Reset pulse during a 10-cycle div busy with a pending lw entry -> next cycle counter=0, all entries invalid, stall=0, Forward=0.
